// File: rtl/pipe_mux_if.sv
// Operand-select stream bundle: upstream offers packed words plus a select, downstream takes the picked word.
interface pipe_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_err, out_valid
  );
endinterface

// File: rtl/pipe_mux.sv
// N-way W-bit registered select; latency 1 cycle from accept to out_* when main is free or draining.
// Backpressure: 2-entry skid (main + skid), in_ready comes from registered state only, never from out_ready.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_mux_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t cap;
  logic   main_ld;
  logic   skid_ld;
  logic   in_fire;
  logic   out_fire;

  // Out-of-range selects yield a zero word with err set, so no X ever reaches the output.
  always_comb begin
    cap     = '0;
    cap.sel = bus.in_sel;
    if (32'(bus.in_sel) >= NUM_IN) begin
      cap.err = 1'b1;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (bus.in_sel == SEL_W'(k)) begin
          cap.data = bus.in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q.data;
  assign bus.out_sel   = main_q.sel;
  assign bus.out_err   = main_q.err;

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = cap;
    skid_d  = cap;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_ld = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_d = TWO;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          main_ld = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // A flush wins over any same-cycle accept; loads are suppressed since the entry is dropped anyway.
    if (bus.flush) begin
      state_d = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (main_ld) begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (skid_ld) begin
      skid_q <= skid_d;
    end
  end

  a_param: assert property (@(posedge clk)
    (NUM_IN >= 2) && (NUM_IN <= 16) && (SEL_W == $clog2(NUM_IN)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready && !bus.flush) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_sel) && $stable(bus.out_err)));

  a_flush: assert property (@(posedge clk) disable iff (!rst_n)
    bus.flush |=> (bus.in_ready && !bus.out_valid));

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: four parameterisations share one generic stimulus bundle routed to the instance under test.
module tb_pipe_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cur    = 0;

  logic [63:0] g_data [16];
  logic [3:0]  g_sel;
  logic        g_vld, g_ordy, g_flush;
  logic [63:0] g_odata;
  logic [3:0]  g_osel;
  logic        g_oerr, g_ovld, g_irdy;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  s;
    logic        e;
  } ent_t;

  pipe_mux_if #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2)) if0 ();
  pipe_mux_if #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2)) if1 ();
  pipe_mux_if #(.WIDTH(8),  .NUM_IN(2),  .SEL_W(1)) if2 ();
  pipe_mux_if #(.WIDTH(64), .NUM_IN(16), .SEL_W(4)) if3 ();

  pipe_mux #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pipe_mux #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipe_mux #(.WIDTH(8),  .NUM_IN(2),  .SEL_W(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  pipe_mux #(.WIDTH(64), .NUM_IN(16), .SEL_W(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  always_comb begin
    for (int k = 0; k < 4; k++) if0.in_data[k*32 +: 32] = g_data[k][31:0];
    if0.in_sel = g_sel[1:0]; if0.in_valid = g_vld && (cur == 0);
    if0.out_ready = g_ordy && (cur == 0); if0.flush = g_flush && (cur == 0);
  end
  always_comb begin
    for (int k = 0; k < 3; k++) if1.in_data[k*32 +: 32] = g_data[k][31:0];
    if1.in_sel = g_sel[1:0]; if1.in_valid = g_vld && (cur == 1);
    if1.out_ready = g_ordy && (cur == 1); if1.flush = g_flush && (cur == 1);
  end
  always_comb begin
    for (int k = 0; k < 2; k++) if2.in_data[k*8 +: 8] = g_data[k][7:0];
    if2.in_sel = g_sel[0:0]; if2.in_valid = g_vld && (cur == 2);
    if2.out_ready = g_ordy && (cur == 2); if2.flush = g_flush && (cur == 2);
  end
  always_comb begin
    for (int k = 0; k < 16; k++) if3.in_data[k*64 +: 64] = g_data[k];
    if3.in_sel = g_sel; if3.in_valid = g_vld && (cur == 3);
    if3.out_ready = g_ordy && (cur == 3); if3.flush = g_flush && (cur == 3);
  end

  always_comb begin
    g_odata = '0; g_osel = '0; g_oerr = 1'b0; g_ovld = 1'b0; g_irdy = 1'b0;
    case (cur)
      0: begin g_odata = 64'(if0.out_data); g_osel = 4'(if0.out_sel); g_oerr = if0.out_err; g_ovld = if0.out_valid; g_irdy = if0.in_ready; end
      1: begin g_odata = 64'(if1.out_data); g_osel = 4'(if1.out_sel); g_oerr = if1.out_err; g_ovld = if1.out_valid; g_irdy = if1.in_ready; end
      2: begin g_odata = 64'(if2.out_data); g_osel = 4'(if2.out_sel); g_oerr = if2.out_err; g_ovld = if2.out_valid; g_irdy = if2.in_ready; end
      default: begin g_odata = if3.out_data; g_osel = if3.out_sel; g_oerr = if3.out_err; g_ovld = if3.out_valid; g_irdy = if3.in_ready; end
    endcase
  end

  task automatic idle();
    g_vld = 1'b0; g_ordy = 1'b0; g_flush = 1'b0; g_sel = '0;
    for (int k = 0; k < 16; k++) g_data[k] = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cur = 0;
    do_reset();
    n_chk++; if (g_ovld !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", g_ovld); end
    n_chk++; if (g_irdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", g_irdy); end
    n_chk++; if (g_odata !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", g_odata); end
    n_chk++; if (g_osel !== 4'h0 || g_oerr !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %h/%b want 0/0", g_osel, g_oerr); end
    g_data[0] = 64'h1111; g_sel = 4'd0; g_vld = 1'b1;
    @(negedge clk); @(negedge clk);
    n_chk++; if (g_irdy !== 1'b0 || g_ovld !== 1'b1) begin n_fail++; $display("FAIL fill_two: got rdy=%b vld=%b want 0/1", g_irdy, g_ovld); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (g_ovld !== 1'b0 || g_irdy !== 1'b1) begin n_fail++; $display("FAIL async_reset: got vld=%b rdy=%b want 0/1", g_ovld, g_irdy); end
    n_chk++; if (g_odata !== 64'h0) begin n_fail++; $display("FAIL async_reset_data: got %h want 0", g_odata); end
    @(negedge clk);
    rst_n = 1'b1;
    g_data[2] = 64'hDEADBEEF; g_sel = 4'd2; g_vld = 1'b1;
    @(negedge clk);
    g_vld = 1'b0;
    n_chk++; if (g_ovld !== 1'b1 || g_odata !== 64'hDEADBEEF || g_osel !== 4'd2) begin
      n_fail++; $display("FAIL first_accept: got vld=%b data=%h sel=%0d want 1/deadbeef/2", g_ovld, g_odata, g_osel);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] exp;
    cur = 0;
    do_reset();
    for (int k = 0; k < 4; k++) g_data[k] = 64'((k + 1) * 16);
    g_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      g_sel = 4'(i % 4); g_vld = 1'b1;
      exp = 64'(((i % 4) + 1) * 16);
      @(negedge clk);
      n_chk++; if (g_ovld !== 1'b1 || g_odata !== exp || g_irdy !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d: got vld=%b data=%h rdy=%b want 1/%h/1", i, g_ovld, g_odata, g_irdy, exp);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    cur = 0;
    do_reset();
    g_data[0] = 64'h1; g_data[1] = 64'h2;
    g_sel = 4'd0; g_vld = 1'b1;
    @(negedge clk);
    n_chk++; if (g_irdy !== 1'b1 || g_odata !== 64'h1) begin n_fail++; $display("FAIL bp_first: got rdy=%b data=%h want 1/1", g_irdy, g_odata); end
    g_sel = 4'd1;
    @(negedge clk);
    g_vld = 1'b0;
    n_chk++; if (g_irdy !== 1'b0 || g_odata !== 64'h1 || g_ovld !== 1'b1) begin n_fail++; $display("FAIL bp_full: got rdy=%b data=%h vld=%b want 0/1/1", g_irdy, g_odata, g_ovld); end
    @(negedge clk);
    n_chk++; if (g_odata !== 64'h1 || g_irdy !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got data=%h rdy=%b want 1/0", g_odata, g_irdy); end
    g_ordy = 1'b1;
    @(negedge clk);
    n_chk++; if (g_odata !== 64'h2 || g_ovld !== 1'b1 || g_irdy !== 1'b1) begin n_fail++; $display("FAIL bp_drain1: got data=%h vld=%b rdy=%b want 2/1/1", g_odata, g_ovld, g_irdy); end
    @(negedge clk);
    n_chk++; if (g_ovld !== 1'b0) begin n_fail++; $display("FAIL bp_drain2: got vld=%b want 0", g_ovld); end
    idle();
  endtask

  task automatic test_bad_select();
    cur = 1;
    do_reset();
    g_data[0] = 64'hA0A0; g_data[1] = 64'hB1B1; g_data[2] = 64'hC2C2; g_data[3] = 64'h5555;
    g_ordy = 1'b1; g_vld = 1'b1; g_sel = 4'd3;
    @(negedge clk);
    n_chk++; if (g_odata !== 64'h0 || g_oerr !== 1'b1 || g_osel !== 4'd3) begin
      n_fail++; $display("FAIL bad_sel: got data=%h err=%b sel=%0d want 0/1/3", g_odata, g_oerr, g_osel);
    end
    g_sel = 4'd1;
    @(negedge clk);
    n_chk++; if (g_odata !== 64'hB1B1 || g_oerr !== 1'b0 || g_osel !== 4'd1) begin
      n_fail++; $display("FAIL sel_recover: got data=%h err=%b sel=%0d want b1b1/0/1", g_odata, g_oerr, g_osel);
    end
    g_sel = 4'd2;
    @(negedge clk);
    n_chk++; if (g_odata !== 64'hC2C2 || g_oerr !== 1'b0) begin n_fail++; $display("FAIL last_legal_sel: got data=%h err=%b want c2c2/0", g_odata, g_oerr); end
    idle();
  endtask

  task automatic test_flush();
    cur = 0;
    do_reset();
    g_data[3] = 64'h77; g_sel = 4'd3; g_vld = 1'b1;
    @(negedge clk); @(negedge clk);
    n_chk++; if (g_irdy !== 1'b0) begin n_fail++; $display("FAIL flush_setup: got rdy=%b want 0", g_irdy); end
    g_flush = 1'b1; g_ordy = 1'b1;
    @(negedge clk);
    g_flush = 1'b0; g_vld = 1'b0;
    n_chk++; if (g_ovld !== 1'b0 || g_irdy !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got vld=%b rdy=%b want 0/1", g_ovld, g_irdy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (g_ovld !== 1'b0) begin n_fail++; $display("FAIL flush_ghost_%0d: got vld=%b want 0", i, g_ovld); end
    end
    idle();
  endtask

  task automatic test_random(input int id, input int width, input int num_in, input int sel_w, input int cycles);
    ent_t        q[$];
    ent_t        e;
    logic [63:0] mask;
    bit          inf, outf;
    mask = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
    cur = id;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      n_chk++; if (g_ovld !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd%0d_valid cyc %0d: got %b want %b", id, i, g_ovld, q.size() != 0); end
      n_chk++; if (g_irdy !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd%0d_ready cyc %0d: got %b want %b", id, i, g_irdy, q.size() < 2); end
      if (q.size() != 0) begin
        n_chk++;
        if (g_odata !== q[0].d || g_osel !== q[0].s || g_oerr !== q[0].e) begin
          n_fail++; $display("FAIL rnd%0d_entry cyc %0d: got %h/%0d/%b want %h/%0d/%b", id, i, g_odata, g_osel, g_oerr, q[0].d, q[0].s, q[0].e);
        end
      end
      if (i < cycles - 4) begin
        g_vld   = ($urandom_range(0, 3) != 0);
        g_ordy  = ($urandom_range(0, 2) != 0);
        g_flush = ($urandom_range(0, 49) == 0);
      end else begin
        g_vld = 1'b0; g_ordy = 1'b1; g_flush = 1'b0;
      end
      for (int k = 0; k < 16; k++) g_data[k] = {$urandom, $urandom} & mask;
      g_sel = 4'($urandom_range(0, (1 << sel_w) - 1));
      inf  = g_vld && (q.size() < 2);
      outf = (q.size() != 0) && g_ordy;
      if (g_flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) begin
          e.e = (int'(g_sel) >= num_in);
          e.d = e.e ? 64'h0 : g_data[g_sel];
          e.s = g_sel;
          q.push_back(e);
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bad_select();
    test_flush();
    test_random(2, 8, 2, 1, 400);
    test_random(3, 64, 16, 4, 400);
    test_random(1, 32, 3, 2, 300);
    test_random(0, 32, 4, 2, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_mux.md
Name: pipe_mux

Overview:
- Parametrised N-way, W-bit operand select with a registered output and valid/ready flow control.
- Generalises the datapath 2:1 word select used throughout the CPU to NUM_IN inputs.
- Adds a 1-cycle pipeline stage plus a 2-entry skid buffer, so it can sit between pipelined CPU stages (e.g. ID→EX operand/forwarding select) without a combinational ready path.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must equal clog2(NUM_IN), minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  selects the input to capture.
- in_valid  input  1  upstream offers in_data/in_sel.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  WIDTH  selected word (registered).
- out_sel  output  SEL_W  in_sel value captured with out_data.
- out_err  output  1  captured in_sel was >= NUM_IN; out_data is 0 in that case.
- out_valid  output  1  out_data/out_sel/out_err are valid.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Reset: rst_n low asynchronously forces state EMPTY. Reset values: out_valid=0, in_ready=1, out_data=0, out_sel=0, out_err=0, skid register=0.
- Reset mid-transfer drops all buffered entries. There is no replay after reset.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Capture: captured entry = {in_data[in_sel], in_sel, err}. If in_sel >= NUM_IN, the word is 0 and err=1. No X propagation.
- Storage: main register drives the outputs; skid register holds one overflow entry. Order is strictly FIFO.
- in_ready = (state != TWO). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Latency: an entry accepted at edge n is visible on out_* after edge n (one cycle) when the block was EMPTY or main was draining.
- State EMPTY:
  - in_fire → ONE, main ← capture.
  - otherwise hold.
- State ONE:
  - in_fire & out_fire → ONE, main ← capture.
  - in_fire & !out_fire → TWO, skid ← capture.
  - !in_fire & out_fire → EMPTY.
  - neither → hold.
- State TWO:
  - out_fire → ONE, main ← skid.
  - otherwise hold; outputs stable.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_sel/out_err must not change.
- Upstream rule: in_valid may deassert without a handshake. in_data/in_sel are sampled only on in_fire.
- flush=1 at an edge:
  - next state EMPTY, regardless of in_fire or out_fire in the same cycle.
  - an input accepted that cycle is discarded.
  - an out_fire that cycle still counts as consumed by downstream.
  - in_ready is 1 in the following cycle.
- Throughput: 1 entry/cycle sustained with out_ready held high. No bubbles in ONE.
- The main register clock enable is active only on main loads, to reduce toggling.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with state TWO → out_valid=0 and in_ready=1 immediately (asynchronously). After release, first accept of in_sel=2 with input2=0xDEADBEEF → out_data=0xDEADBEEF and out_valid=1 one cycle later.
- Streaming: out_ready=1 and in_valid=1 for 8 cycles with in_sel cycling 0..3 on inputs 0x10,0x20,0x30,0x40 → outputs 0x10,0x20,0x30,0x40,0x10,… on consecutive cycles, in_ready constant 1.
- Backpressure: out_ready=0, push A=0x1 then B=0x2 → in_ready=0 after the second accept; out_data holds 0x1. Raise out_ready → outputs 0x1 then 0x2 in order, in_ready=1 the cycle after the first drain.
- Bad select: NUM_IN=3, SEL_W=2, in_sel=3 → out_data=0, out_err=1, out_sel=3. The next accept with in_sel=1 clears out_err.
- Flush: state TWO with flush=1, in_valid=1, out_ready=1 in the same cycle → next cycle out_valid=0, in_ready=1; no entry appears later.
- Parameter sweep: WIDTH=8/NUM_IN=2/SEL_W=1 and WIDTH=64/NUM_IN=16/SEL_W=4 → random valid/ready traffic matches a scoreboard model with no loss, duplication or reordering.
